// File: rtl/pattern_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pattern_detect_ctrl
// Description : Programmable non-overlapping Mealy serial pattern detector
//               with IDLE/RUN/DONE run sequencing, match counting,
//               threshold completion and sticky counter overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_detect_ctrl #(
  parameter int                   PAT_LEN     = 4,
  parameter int                   CNT_W       = 8,
  parameter logic [PAT_LEN-1:0]   RST_PATTERN = 4'b1011
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic [CNT_W-1:0]   cfg_threshold,
  input  logic               start,
  input  logic               stop,
  input  logic               bit_valid,
  input  logic               a,
  output logic               y,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   match_count,
  output logic               ovf
);

  // fill only ever needs to reach PAT_LEN-1
  localparam int                FILL_W   = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [PAT_LEN-1:0]   r_pattern;
  logic [CNT_W-1:0]     r_threshold;
  logic [PAT_LEN-2:0]   r_hist;
  logic [FILL_W-1:0]    r_fill;
  logic [CNT_W-1:0]     r_count;
  logic                 r_ovf;

  logic [PAT_LEN-1:0]   w_cand;
  logic                 w_match;
  logic                 w_thr_hit;
  logic                 w_run_entry;
  logic                 w_cfg_ok;

  // Match detection and the conditions derived from it
  always_comb begin
    w_cand    = {r_hist, a};
    w_match   = (r_state == ST_RUN) && bit_valid && (r_fill >= FILL_MAX) &&
                (w_cand == r_pattern);
    // Widened compare so a saturated counter can never wrap onto the threshold
    w_thr_hit = w_match && (r_threshold != '0) &&
                (({1'b0, r_count} + (CNT_W+1)'(1)) == {1'b0, r_threshold});
    w_cfg_ok  = (r_state != ST_RUN);
  end

  // Next-state selection; completion beats stop, start beats stop in DONE
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next_state = ST_RUN;
      ST_RUN: begin
        if (w_thr_hit)   w_next_state = ST_DONE;
        else if (stop)   w_next_state = ST_IDLE;
      end
      ST_DONE: begin
        if (start)       w_next_state = ST_RUN;
        else if (stop)   w_next_state = ST_IDLE;
      end
      default:           w_next_state = ST_IDLE;
    endcase
    w_run_entry = (r_state != ST_RUN) && (w_next_state == ST_RUN);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Configuration registers; frozen while a run is in progress
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pattern   <= RST_PATTERN;
      r_threshold <= '0;
    end else if (cfg_load && w_cfg_ok) begin
      r_pattern   <= cfg_pattern;
      r_threshold <= cfg_threshold;
    end
  end

  // Shift history, fill level, match counter and overflow flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_run_entry) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if ((r_state == ST_RUN) && bit_valid) begin
      r_hist <= w_cand[PAT_LEN-2:0];
      if (w_match) begin
        // Matched bits are consumed so patterns never overlap
        r_fill <= '0;
        if (&r_count) r_ovf   <= 1'b1;
        else          r_count <= r_count + CNT_W'(1);
      end else if (r_fill < FILL_MAX) begin
        r_fill <= r_fill + FILL_W'(1);
      end
    end
  end

  // Output decodes
  always_comb begin
    y           = w_match;
    busy        = (r_state == ST_RUN);
    done        = (r_state == ST_DONE);
    match_count = r_count;
    ovf         = r_ovf;
  end

endmodule
`default_nettype wire
